// File: rtl/bc_pkg.sv
// Basic Computer shared definitions: datapath width and ALU operation encodings.
// The controller drives its op field with the same localparams.
package bc_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_LDA  = 3'b010;
    localparam logic [2:0] ALU_CMA  = 3'b011;
    localparam logic [2:0] ALU_CIL  = 3'b100;
    localparam logic [2:0] ALU_CIR  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;
    localparam logic [2:0] ALU_NOP  = 3'b111;

endpackage

// File: rtl/ac_alu_unit_alu_core.sv
// Purely combinational ALU for the accumulator stage.
// e_valid flags the ops that produce a new E value (ADD carry, CIL, CIR).
module alu_core
    import bc_pkg::*;
#(
    parameter int WIDTH = bc_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] ac,
    input  logic [WIDTH-1:0] dr,
    input  logic             e,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             e_next,
    output logic             e_valid,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum_s;

    assign sum_s = {1'b0, ac} + {1'b0, dr};

    // Operation decode; unknown or idle codes pass AC through with no side effects.
    always_comb begin
        result   = ac;
        e_next   = e;
        e_valid  = 1'b0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op)
            ALU_AND: result = ac & dr;
            ALU_ADD: begin
                result   = sum_s[WIDTH-1:0];
                carry    = sum_s[WIDTH];
                overflow = (ac[WIDTH-1] == dr[WIDTH-1]) && (sum_s[WIDTH-1] != ac[WIDTH-1]);
                e_next   = sum_s[WIDTH];
                e_valid  = 1'b1;
            end
            ALU_LDA: result = dr;
            ALU_CMA: result = ~ac;
            ALU_CIL: begin
                result  = {ac[WIDTH-2:0], e};
                e_next  = ac[WIDTH-1];
                e_valid = 1'b1;
            end
            ALU_CIR: begin
                result  = {e, ac[WIDTH-1:1]};
                e_next  = ac[0];
                e_valid = 1'b1;
            end
            ALU_PASS: result = ac;
            ALU_NOP:  result = ac;
            default:  result = ac;
        endcase
    end

endmodule

// File: rtl/ac_alu_unit.sv
// Accumulator datapath stage: owns AC, E and the registered carry/overflow
// status, resolving the controller's AC/E strobes by fixed priority.
module ac_alu_unit
    import bc_pkg::*;
#(
    parameter int WIDTH = bc_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dr,
    input  logic [2:0]       alu_op,
    input  logic             ac_ld,
    input  logic             ac_inr,
    input  logic             ac_clr,
    input  logic             e_clr,
    input  logic             e_cmp,
    output logic [WIDTH-1:0] ac,
    output logic             e,
    output logic             co,
    output logic             ovf,
    output logic             z,
    output logic             n
);

    logic [WIDTH-1:0] ac_q, ac_d;
    logic             e_q, e_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] alu_result_s;
    logic             alu_e_next_s, alu_e_valid_s, alu_carry_s, alu_ovf_s;
    logic [WIDTH:0]   inc_s;
    logic             ld_win_s;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .ac       (ac_q),
        .dr       (dr),
        .e        (e_q),
        .alu_op   (alu_op),
        .result   (alu_result_s),
        .e_next   (alu_e_next_s),
        .e_valid  (alu_e_valid_s),
        .carry    (alu_carry_s),
        .overflow (alu_ovf_s)
    );

    assign inc_s    = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};
    assign ld_win_s = !ac_clr && ac_ld;

    // AC/status next-state: clear > load > increment > hold; clear keeps co/ovf.
    always_comb begin
        ac_d  = ac_q;
        co_d  = co_q;
        ovf_d = ovf_q;
        if (ac_clr) begin
            ac_d = {WIDTH{1'b0}};
        end else if (ac_ld) begin
            ac_d = alu_result_s;
            if (alu_op == ALU_ADD) begin
                co_d  = alu_carry_s;
                ovf_d = alu_ovf_s;
            end else begin
                co_d  = co_q;
                ovf_d = ovf_q;
            end
        end else if (ac_inr) begin
            ac_d  = inc_s[WIDTH-1:0];
            co_d  = inc_s[WIDTH];
            ovf_d = (ac_q == {1'b0, {(WIDTH-1){1'b1}}});
        end else begin
            ac_d = ac_q;
        end
    end

    // E next-state: explicit strobes beat any ALU-generated value.
    always_comb begin
        e_d = e_q;
        if (e_clr) begin
            e_d = 1'b0;
        end else if (e_cmp) begin
            e_d = ~e_q;
        end else if (ld_win_s && alu_e_valid_s) begin
            e_d = alu_e_next_s;
        end else begin
            e_d = e_q;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q  <= {WIDTH{1'b0}};
            e_q   <= 1'b0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ac_q  <= ac_d;
            e_q   <= e_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign ac  = ac_q;
    assign e   = e_q;
    assign co  = co_q;
    assign ovf = ovf_q;
    assign z   = (ac_q == {WIDTH{1'b0}});
    assign n   = ac_q[WIDTH-1];

endmodule

// File: tb/tb_ac_alu_unit.sv
// Directed scoreboard bench for ac_alu_unit: each step pushes the expected
// AC/E/CO/OVF, clocks once, then pops and checks all six outputs.
module tb_ac_alu_unit;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_CMA = 3'b011;
    localparam logic [2:0] OP_CIL = 3'b100;
    localparam logic [2:0] OP_CIR = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dr;
    logic [2:0]  alu_op;
    logic        ac_ld, ac_inr, ac_clr, e_clr, e_cmp;
    logic [15:0] ac;
    logic        e, co, ovf, z, n;

    typedef struct {
        string       tag;
        logic [15:0] ac;
        logic        e;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    ac_alu_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dr     (dr),
        .alu_op (alu_op),
        .ac_ld  (ac_ld),
        .ac_inr (ac_inr),
        .ac_clr (ac_clr),
        .e_clr  (e_clr),
        .e_cmp  (e_cmp),
        .ac     (ac),
        .e      (e),
        .co     (co),
        .ovf    (ovf),
        .z      (z),
        .n      (n)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] eac, input logic ee, input logic eco, input logic eovf);
        exp_t x;
        x.tag = tag; x.ac = eac; x.e = ee; x.co = eco; x.ovf = eovf;
        sb.push_back(x);
    endtask

    task automatic check_pop();
        exp_t x;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            x = sb.pop_front();
            cmp(x.tag, "ac",  ac,  x.ac);
            cmp(x.tag, "e",   {15'd0, e},   {15'd0, x.e});
            cmp(x.tag, "co",  {15'd0, co},  {15'd0, x.co});
            cmp(x.tag, "ovf", {15'd0, ovf}, {15'd0, x.ovf});
            cmp(x.tag, "z",   {15'd0, z},   {15'd0, (x.ac == 16'h0000)});
            cmp(x.tag, "n",   {15'd0, n},   {15'd0, x.ac[15]});
        end
    endtask

    // One clocked step: drive strobes, record expectation, clock, check after the edge.
    task automatic step(input string tag, input logic [2:0] op, input logic [15:0] d,
                        input logic ld, input logic inr, input logic clr,
                        input logic eclr, input logic ecmp,
                        input logic [15:0] eac, input logic ee, input logic eco, input logic eovf);
        @(negedge clk);
        alu_op = op; dr = d; ac_ld = ld; ac_inr = inr; ac_clr = clr; e_clr = eclr; e_cmp = ecmp;
        push(tag, eac, ee, eco, eovf);
        @(posedge clk);
        #1;
        check_pop();
        alu_op = OP_NOP; ac_ld = 1'b0; ac_inr = 1'b0; ac_clr = 1'b0; e_clr = 1'b0; e_cmp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dr = 16'h0000; alu_op = OP_NOP;
        ac_ld = 1'b0; ac_inr = 1'b0; ac_clr = 1'b0; e_clr = 1'b0; e_cmp = 1'b0;
        #1;
        push("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_pop();
        #12;
        rst_n = 1'b1;

        //   tag         op      dr        ld    inr   clr   eclr  ecmp  ac        e     co    ovf
        step("lda7fff",  OP_LDA, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        step("add_ovf",  OP_ADD, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        step("ldaffff",  OP_LDA, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        step("add_cy",   OP_ADD, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0);
        step("lda8001",  OP_LDA, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 1'b1, 1'b1, 1'b0);
        step("cil",      OP_CIL, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0);
        step("cir",      OP_CIR, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 1'b1, 1'b1, 1'b0);
        step("clr_prio", OP_ADD, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step("ldaf0f0",  OP_LDA, 16'hF0F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF0F0, 1'b1, 1'b1, 1'b0);
        step("and",      OP_AND, 16'h3C3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3030, 1'b1, 1'b1, 1'b0);
        step("cma",      OP_CMA, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCFCF, 1'b1, 1'b1, 1'b0);
        step("eclr_add", OP_ADD, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0FCF, 1'b0, 1'b1, 1'b0);
        step("ecmp",     OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0FCF, 1'b1, 1'b1, 1'b0);
        step("lda7fff2", OP_LDA, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        step("inr_ovf",  OP_NOP, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        step("ldaffff2", OP_LDA, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        step("inr_wrap", OP_ADD, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step("idle",     OP_NOP, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step("lda1234",  OP_LDA, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0);
        step("nop_ld",   OP_NOP, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0);
        step("xop_idle", 3'bxxx, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a pending ADD load.
        @(negedge clk);
        alu_op = OP_ADD; dr = 16'h0001; ac_ld = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        push("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_pop();
        @(posedge clk);
        #1;
        push("rst_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_pop();
        @(negedge clk);
        rst_n = 1'b1; ac_ld = 1'b0; alu_op = OP_NOP;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
